// File: rtl/id_ex_pipe_reg.sv
// ID->EX elastic pipeline register: output stage plus one-entry skid buffer, with load-use hazard stall.
// Optional ID_EX_STALL_CNT_EN adds a saturating load-use stall counter on stall_cnt_o.
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH         = 32,
  parameter int REG_MEM_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          id_valid_i,
  output logic                          id_ready_o,
  input  logic [DATA_WIDTH-1:0]         pc_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic                          rs1_used_i,
  input  logic                          rs2_used_i,
  input  logic [DATA_WIDTH-1:0]         rs1_data_i,
  input  logic [DATA_WIDTH-1:0]         rs2_data_i,
  input  logic [DATA_WIDTH-1:0]         imm_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                          rd_wr_en_i,
  input  logic                          is_load_i,
  input  logic [CTRL_WIDTH-1:0]         ctrl_i,
  output logic                          ex_valid_o,
  input  logic                          ex_ready_i,
  output logic [DATA_WIDTH-1:0]         ex_pc_o,
  output logic [REG_MEM_ADDR_WIDTH-1:0] ex_rs1_addr_o,
  output logic [REG_MEM_ADDR_WIDTH-1:0] ex_rs2_addr_o,
  output logic [DATA_WIDTH-1:0]         ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0]         ex_rs2_data_o,
  output logic [DATA_WIDTH-1:0]         ex_imm_o,
  output logic [REG_MEM_ADDR_WIDTH-1:0] ex_rd_addr_o,
  output logic                          ex_rd_wr_en_o,
  output logic                          ex_is_load_o,
  output logic [CTRL_WIDTH-1:0]         ex_ctrl_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cnt_o
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]         pc;
    logic [REG_MEM_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_MEM_ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0]         rs1_data;
    logic [DATA_WIDTH-1:0]         rs2_data;
    logic [DATA_WIDTH-1:0]         imm;
    logic [REG_MEM_ADDR_WIDTH-1:0] rd_addr;
    logic                          rd_wr_en;
    logic                          is_load;
    logic [CTRL_WIDTH-1:0]         ctrl;
  } payload_t;

  payload_t in_p0;
  payload_t o_pl_p1;
  payload_t s_pl_p1;
  logic     o_vld_p1;
  logic     s_vld_p1;
  logic     hazard;
  logic     accept;
  logic     rs1_hit;
  logic     rs2_hit;

  // Stage 0: incoming instruction from ID and handshake decode
  assign in_p0 = {pc_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, imm_i,
                  rd_addr_i, rd_wr_en_i, is_load_i, ctrl_i};

  assign rs1_hit = rs1_used_i && (rs1_addr_i == o_pl_p1.rd_addr);
  assign rs2_hit = rs2_used_i && (rs2_addr_i == o_pl_p1.rd_addr);

  // A load sitting in O has not produced its data yet; x0 is never a real dependency.
  assign hazard = o_vld_p1 && o_pl_p1.is_load && o_pl_p1.rd_wr_en &&
                  (o_pl_p1.rd_addr != '0) && (rs1_hit || rs2_hit);

  assign id_ready_o = !s_vld_p1 && !hazard && !flush_i;
  assign accept     = id_valid_i && id_ready_o;

  // Stage 1: output register O and skid buffer S
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld_p1 <= 1'b0;
      s_vld_p1 <= 1'b0;
      o_pl_p1  <= '0;
      s_pl_p1  <= '0;
    end else if (flush_i) begin
      o_vld_p1 <= 1'b0;
      s_vld_p1 <= 1'b0;
    end else if (!o_vld_p1 || ex_ready_i) begin
      if (s_vld_p1) begin
        o_pl_p1  <= s_pl_p1;
        o_vld_p1 <= 1'b1;
        s_vld_p1 <= 1'b0;
      end else if (accept) begin
        o_pl_p1  <= in_p0;
        o_vld_p1 <= 1'b1;
      end else begin
        o_vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      // O is stalled by EX: park the new instruction so ready never waits on ex_ready_i
      s_pl_p1  <= in_p0;
      s_vld_p1 <= 1'b1;
    end
  end

  assign ex_valid_o    = o_vld_p1;
  assign ex_pc_o       = o_pl_p1.pc;
  assign ex_rs1_addr_o = o_pl_p1.rs1_addr;
  assign ex_rs2_addr_o = o_pl_p1.rs2_addr;
  assign ex_rs1_data_o = o_pl_p1.rs1_data;
  assign ex_rs2_data_o = o_pl_p1.rs2_data;
  assign ex_imm_o      = o_pl_p1.imm;
  assign ex_rd_addr_o  = o_pl_p1.rd_addr;
  assign ex_rd_wr_en_o = o_pl_p1.rd_wr_en;
  assign ex_is_load_o  = o_pl_p1.is_load;
  assign ex_ctrl_o     = o_pl_p1.ctrl;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_p1;

  // Stage 1: load-use stall counter, saturating, survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_p1 <= 32'd0;
    end else if (id_valid_i && hazard && (stall_cnt_p1 != 32'hFFFF_FFFF)) begin
      stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_p1;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: accepted instructions are queued and matched in order on EX handshakes.
module tb_id_ex_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int PW = 4*DW + 3*AW + 2 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          id_valid_i;
  logic          id_ready_o;
  logic [DW-1:0] pc_i;
  logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic          rs1_used_i, rs2_used_i, rd_wr_en_i, is_load_i;
  logic [DW-1:0] rs1_data_i, rs2_data_i, imm_i;
  logic [CW-1:0] ctrl_i;
  logic          ex_valid_o, ex_ready_i;
  logic [DW-1:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [AW-1:0] ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
  logic          ex_rd_wr_en_o, ex_is_load_o;
  logic [CW-1:0] ex_ctrl_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0]   stall_cnt_o;
`endif

  int n_chk = 0;
  int n_bad = 0;
  logic [PW-1:0] sb_q[$];

  id_ex_pipe_reg #(.DATA_WIDTH(DW), .REG_MEM_ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .pc_i(pc_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rd_addr_i(rd_addr_i), .rd_wr_en_i(rd_wr_en_i), .is_load_i(is_load_i), .ctrl_i(ctrl_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_pc_o(ex_pc_o), .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_wr_en_o(ex_rd_wr_en_o), .ex_is_load_o(ex_is_load_o),
    .ex_ctrl_o(ex_ctrl_o)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] in_pack();
    return {pc_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, imm_i,
            rd_addr_i, rd_wr_en_i, is_load_i, ctrl_i};
  endfunction

  function automatic logic [PW-1:0] out_pack();
    return {ex_pc_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
            ex_rd_addr_o, ex_rd_wr_en_o, ex_is_load_o, ex_ctrl_o};
  endfunction

  task automatic drive(input logic [DW-1:0] pc, input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2,
                       input logic [AW-1:0] rd, input logic ld);
    id_valid_i = 1'b1;
    pc_i       = pc;
    rs1_addr_i = rs1;
    rs1_used_i = u1;
    rs2_addr_i = rs2;
    rs2_used_i = u2;
    rd_addr_i  = rd;
    rd_wr_en_i = 1'b1;
    is_load_i  = ld;
    rs1_data_i = pc ^ 32'h1111_0000;
    rs2_data_i = pc + 32'h0000_2222;
    imm_i      = ~pc;
    ctrl_i     = pc[15:0] ^ 16'hA5A5;
  endtask

  // Evaluate the handshakes that the coming edge will act on, then advance one cycle.
  task automatic tick();
    #1;
    if (flush_i) begin
      sb_q.delete();
    end else begin
      if (ex_valid_o && ex_ready_i) begin
        if (sb_q.size() == 0) chk("sb_unexpected", 1, 0);
        else chk("payload", out_pack(), sb_q.pop_front());
      end
      if (id_valid_i && id_ready_o) sb_q.push_back(in_pack());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    id_valid_i = 1'b0;
    ex_ready_i = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    chk("drain_left", sb_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b1;
    id_valid_i = 1'b0; pc_i = '0; rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
    rs1_used_i = 1'b0; rs2_used_i = 1'b0; rd_wr_en_i = 1'b0; is_load_i = 1'b0;
    rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; ctrl_i = '0;
    #2;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_payload", out_pack(), 0);
    chk("rst_ready", id_ready_o, 1);
`ifdef ID_EX_STALL_CNT_EN
    chk("rst_cnt", stall_cnt_o, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // back-to-back, no gaps
    for (int i = 0; i < 3; i++) begin
      drive(32'(i*4), 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b0);
      tick();
      chk("b2b_valid", ex_valid_o, 1);
      chk("b2b_pc", ex_pc_o, 32'(i*4));
    end
    id_valid_i = 1'b0;
    tick();
    chk("b2b_idle", ex_valid_o, 0);

    // backpressure: A in O, B in S, C refused
    ex_ready_i = 1'b0;
    drive(32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b0);
    tick();
    drive(32'h104, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b0);
    tick();
    drive(32'h108, 5'd3, 1'b1, 5'd4, 1'b1, 5'd10, 1'b0);
    #1;
    chk("bp_ready_full", id_ready_o, 0);
    chk("bp_pc_hold1", ex_pc_o, 32'h100);
    tick();
    chk("bp_pc_hold2", ex_pc_o, 32'h100);
    chk("bp_valid_hold", ex_valid_o, 1);
    id_valid_i = 1'b0;
    ex_ready_i = 1'b1;
    tick();
    chk("bp_skid_to_o", ex_pc_o, 32'h104);
    chk("bp_ready_back", id_ready_o, 1);
    drain();

    // load-use, three times
    for (int i = 0; i < 3; i++) begin
      drive(32'h200 + 32'(i*16), 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      tick();
      drive(32'h204 + 32'(i*16), 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0);
      rs1_data_i = 32'hDEAD_0000;
      #1;
      chk("lu_ready_stall", id_ready_o, 0);
      tick();
      chk("lu_bubble", ex_valid_o, 0);
      rs1_data_i = 32'hBEEF_0000 + 32'(i);
      #1;
      chk("lu_ready_free", id_ready_o, 1);
      tick();
      chk("lu_pc", ex_pc_o, 32'h204 + 32'(i*16));
      chk("lu_fresh_rs1", ex_rs1_data_o, 32'hBEEF_0000 + 32'(i));
    end
    drain();
`ifdef ID_EX_STALL_CNT_EN
    chk("stall_cnt3", stall_cnt_o, 3);
`endif

    // x0 destination and unused rs2 never stall
    drive(32'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    tick();
    drive(32'h304, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b0);
    #1;
    chk("x0_no_stall", id_ready_o, 1);
    tick();
    drive(32'h308, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    drive(32'h30C, 5'd1, 1'b1, 5'd5, 1'b0, 5'd6, 1'b0);
    #1;
    chk("rs2_unused_no_stall", id_ready_o, 1);
    tick();
    drain();

    // flush with O and S full
    ex_ready_i = 1'b0;
    drive(32'h400, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b0);
    tick();
    drive(32'h404, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b0);
    tick();
    drive(32'h408, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b0);
    flush_i = 1'b1;
    #1;
    chk("flush_ready", id_ready_o, 0);
    tick();
    flush_i = 1'b0;
    id_valid_i = 1'b0;
    #1;
    chk("flush_valid", ex_valid_o, 0);
    chk("flush_ready_after", id_ready_o, 1);
    ex_ready_i = 1'b1;
    tick();
    chk("flush_no_accept", ex_valid_o, 0);
    drain();

    // async reset mid-stream
    ex_ready_i = 1'b0;
    drive(32'h500, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    drive(32'h504, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0);
    tick();
    chk("pre_rst_valid", ex_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", ex_valid_o, 0);
    chk("async_rst_pc", ex_pc_o, 0);
`ifdef ID_EX_STALL_CNT_EN
    chk("async_rst_cnt", stall_cnt_o, 0);
`endif
    sb_q.delete();
    id_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ex_ready_i = 1'b1;
    tick();
    chk("post_rst_idle", ex_valid_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
